sprite_linebuf: RTL
===================

SPRITE_LINEBUF -- requirements
Module: sprite_linebuf

Interface
REQ-001 clk  in  1  system clock; all logic rising-edge; CE_PIX and LINE_START are single-clk strobes in this domain.
REQ-002 nRESET  in  1  reset, synchronous, active-low.
REQ-003 LINE_START  in  1  one-clk pulse at start of each scanline; swaps buffer banks.
REQ-004 CE_PIX  in  1  display pixel strobe (6 MHz rate); consecutive pulses at least 2 clk apart.
REQ-005 LOAD  in  1  one-clk pulse; latches SPR_X, SPR_PAL, HFLIP as the start of a new sprite strip.
REQ-006 SPR_X  in  8  strip start X position.
REQ-007 SPR_PAL  in  7  strip palette number.
REQ-008 HFLIP  in  1  strip pixel order: 0 normal, 1 reversed.
REQ-009 CROM_DATA  in  16  four 4bpp pixels from graphics ROM.
REQ-010 DATA_VALID  in  1  one-clk pulse; CROM_DATA is valid in that cycle.
REQ-011 WR_BUSY  out  1  high while clearing or writing; new LOAD/DATA_VALID not accepted.
REQ-012 OVERRUN  out  1  sticky error flag; cleared on LINE_START.
REQ-013 PIX_OUT  out  11  {palette[6:0], color[3:0]} of the current display pixel; 0 = transparent.

Function
REQ-014 Storage SHALL be 2 banks x 256 entries x 11 bits; BANK bit selects write bank = BANK and read bank = ~BANK.
REQ-015 LINE_START SHALL toggle BANK, reset RD_X to 0 and clear OVERRUN, all in the same clk.
REQ-016 The writer FSM SHALL have states CLEAR, IDLE and WRITE; a pixel sub-counter PIX_IDX (0..3) applies in WRITE.
REQ-017 CLEAR: write 0 to all 512 entries, one per clk, address 0..511 ascending; then go to IDLE; WR_BUSY=1 throughout.
REQ-018 IDLE + LOAD: latch WR_X=SPR_X, PAL=SPR_PAL, FLIP=HFLIP; stay in IDLE.
REQ-019 IDLE + DATA_VALID in cycle n: latch CROM_DATA; go to WRITE; write pixels in cycles n+1..n+4; WR_BUSY=1 in n+1..n+4; return to IDLE at n+5.
REQ-020 Pixel order SHALL be: FLIP=0 -> nibbles [15:12],[11:8],[7:4],[3:0]; FLIP=1 -> [3:0],[7:4],[11:8],[15:12].
REQ-021 Each WRITE cycle SHALL store {PAL, nibble} at write bank, address WR_X, when nibble != 0; a nibble of 0 leaves the entry unchanged.
REQ-022 WR_X SHALL increment by 1 after every WRITE cycle, including skipped transparent pixels, modulo 256 (255 wraps to 0).
REQ-023 LOAD and DATA_VALID in the same IDLE cycle: apply LOAD first; the word uses the new X, PAL and FLIP.
REQ-024 LOAD or DATA_VALID while WR_BUSY=1: ignore the input and set OVERRUN=1.
REQ-025 LINE_START during WRITE: abort the remaining pixels and go to IDLE; pixels already written stay in the old bank.
REQ-026 LINE_START during CLEAR: toggle BANK and reset RD_X, but continue CLEAR to completion.
REQ-027 On CE_PIX in cycle m, outside CLEAR: read read bank at RD_X; register the result to PIX_OUT at end of cycle m (visible m+1); in m+1 write 0 to that entry (clear-after-read); increment RD_X mod 256 at end of m.
REQ-028 PIX_OUT SHALL hold its value between CE_PIX strobes.
REQ-029 During CLEAR, PIX_OUT SHALL be 0; RD_X still advances on CE_PIX.
REQ-030 Writer and reader SHALL never access the same bank in the same cycle, except in CLEAR, which owns both ports.

Reset
REQ-031 While nRESET=0 at a clk edge: state=CLEAR, clear address=0, BANK=0, WR_X=0, PAL=0, FLIP=0, RD_X=0, PIX_OUT=0, WR_BUSY=1, OVERRUN=0.
REQ-032 After nRESET goes high, CLEAR SHALL run its full 512 cycles before IDLE, even if reset was asserted mid-CLEAR or mid-WRITE.

Verification
REQ-033 Reset release -> WR_BUSY=1 for exactly 512 clk, then 0; a full line read afterwards gives PIX_OUT=0 at all 256 positions.
REQ-034 LOAD X=0x10, PAL=0x05, FLIP=0; DATA_VALID 0x1230; LINE_START -> pixels 0x10..0x12 read 0x051, 0x052, 0x053; 0x13 reads 0; the next line after the following swap reads 0 at 0x10..0x12.
REQ-035 Same data with FLIP=1 -> 0x10 reads 0, 0x11..0x13 read 0x053, 0x052, 0x051.
REQ-036 X=0xFE, data 0xAAAA -> entries 0xFE, 0xFF, 0x00, 0x01 = {PAL, 0xA}; OVERRUN stays 0.
REQ-037 Second DATA_VALID 2 clk after the first -> ignored and OVERRUN=1 until next LINE_START; LINE_START 2 clk after DATA_VALID -> only the first 1 pixel is written.
REQ-038 Two overlapping strips, second over first at the same X: opaque pixels of the second overwrite; transparent (0) pixels of the second keep the first strip's values.

Source files
------------

// File: rtl/sprite_linebuf.sv
// Double-banked sprite line buffer: a writer FSM paints 4-pixel ROM words into one bank while the other bank is scanned out and cleared behind the read.
// Latency: PIX_OUT updates one clk after CE_PIX. While WR_BUSY is high, new LOAD/DATA_VALID are dropped and flagged on OVERRUN.
module sprite_linebuf (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        LINE_START,
  input  logic        CE_PIX,
  input  logic        LOAD,
  input  logic [7:0]  SPR_X,
  input  logic [6:0]  SPR_PAL,
  input  logic        HFLIP,
  input  logic [15:0] CROM_DATA,
  input  logic        DATA_VALID,
  output logic        WR_BUSY,
  output logic        OVERRUN,
  output logic [10:0] PIX_OUT
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE} state_t;

  state_t      state;
  logic [8:0]  clr_addr;
  logic        bank;
  logic [7:0]  wr_x;
  logic [7:0]  rd_x;
  logic [6:0]  pal;
  logic        flip;
  logic [15:0] data;
  logic [1:0]  pix_idx;
  logic        clr_pend;
  logic [8:0]  clr_pend_addr;
  logic [10:0] mem [0:511];

  logic [1:0]  nib_sel;
  logic [3:0]  nib;
  logic        wr_en;
  logic        busy_hit;
  logic [10:0] rd_dat;

  // Unflipped strips emit the most significant nibble first.
  assign nib_sel  = flip ? pix_idx : ~pix_idx;
  assign nib      = data[{nib_sel, 2'b00} +: 4];
  assign wr_en    = (state == S_WRITE) && !LINE_START && (nib != 4'd0);
  assign busy_hit = WR_BUSY && (LOAD || DATA_VALID);
  assign rd_dat   = mem[{~bank, rd_x}];

  // Writer and clear-after-read target opposite banks, except right after a swap.
  always_ff @(posedge clk) begin
    if (nRESET) begin
      if (state == S_CLEAR) begin
        mem[clr_addr] <= '0;
      end else begin
        if (clr_pend) mem[clr_pend_addr] <= '0;
        if (wr_en)    mem[{bank, wr_x}] <= {pal, nib};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state         <= S_CLEAR;
      clr_addr      <= '0;
      bank          <= 1'b0;
      wr_x          <= '0;
      pal           <= '0;
      flip          <= 1'b0;
      data          <= '0;
      pix_idx       <= '0;
      rd_x          <= '0;
      PIX_OUT       <= '0;
      WR_BUSY       <= 1'b1;
      OVERRUN       <= 1'b0;
      clr_pend      <= 1'b0;
      clr_pend_addr <= '0;
    end else begin
      if (LINE_START) bank <= ~bank;

      if (busy_hit)        OVERRUN <= 1'b1;
      else if (LINE_START) OVERRUN <= 1'b0;

      if (state == S_CLEAR)  PIX_OUT <= '0;
      else if (CE_PIX)       PIX_OUT <= rd_dat;
      clr_pend      <= CE_PIX && (state != S_CLEAR);
      clr_pend_addr <= {~bank, rd_x};

      if (LINE_START)  rd_x <= '0;
      else if (CE_PIX) rd_x <= rd_x + 8'd1;

      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 9'd1;
          if (clr_addr == 9'd511) begin
            state   <= S_IDLE;
            WR_BUSY <= 1'b0;
          end
        end
        S_IDLE: begin
          if (LOAD) begin
            wr_x <= SPR_X;
            pal  <= SPR_PAL;
            flip <= HFLIP;
          end
          if (DATA_VALID) begin
            data    <= CROM_DATA;
            pix_idx <= '0;
            state   <= S_WRITE;
            WR_BUSY <= 1'b1;
          end
        end
        S_WRITE: begin
          if (LINE_START) begin
            state   <= S_IDLE;
            WR_BUSY <= 1'b0;
          end else begin
            wr_x    <= wr_x + 8'd1;
            pix_idx <= pix_idx + 2'd1;
            if (pix_idx == 2'd3) begin
              state   <= S_IDLE;
              WR_BUSY <= 1'b0;
            end
          end
        end
        default: begin
          state   <= S_CLEAR;
          WR_BUSY <= 1'b1;
        end
      endcase
    end
  end

endmodule
